// File: rtl/alu_result_checker.sv
// Response monitor for the ALU: recomputes each sampled op with a golden model,
// compares it against result_i after LATENCY cycles, and keeps pass/fail/skip status.
module alu_result_checker #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic [5:0]       ALUop_i,
  input  logic [31:0]      operand_A_i,
  input  logic [31:0]      operand_B_i,
  input  logic [31:0]      result_i,
  output logic [CNT_W-1:0] pass_count_o,
  output logic [CNT_W-1:0] fail_count_o,
  output logic [CNT_W-1:0] skip_count_o,
  output logic             error_o,
  output logic [5:0]       first_fail_op_o,
  output logic [31:0]      first_fail_exp_o,
  output logic [31:0]      first_fail_act_o
);

  typedef struct packed {
    logic        skip;
    logic [5:0]  op;
    logic [31:0] exp;
  } entry_t;

  // Returns {unsupported, expected}.
  function automatic logic [32:0] golden(input logic [5:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    golden = 33'd0;
    case (op)
      6'b000000: golden[31:0] = a + b;
      6'b000001: golden[31:0] = a << sh;
      6'b000010: golden[31:0] = {31'd0, ($signed(a) < $signed(b))};
      6'b000011: golden[31:0] = {31'd0, (a < b)};
      6'b000100: golden[31:0] = a ^ b;
      6'b000101: golden[31:0] = a >> sh;
      6'b000110: golden[31:0] = a | b;
      6'b000111: golden[31:0] = a & b;
      6'b001000: golden[31:0] = a - b;
      6'b001101: golden[31:0] = $unsigned($signed(a) >>> sh);
      default:   golden[32]   = 1'b1;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  logic        s0_vld;
  entry_t      s0_dat;
  logic [32:0] s0_gold;
  logic        cmp_vld;
  entry_t      cmp_dat;

  always_comb begin
    s0_gold     = golden(ALUop_i, operand_A_i, operand_B_i);
    s0_vld      = valid_i;
    s0_dat.skip = s0_gold[32];
    s0_dat.op   = ALUop_i;
    s0_dat.exp  = s0_gold[31:0];
  end

  generate
    if (LATENCY == 0) begin : g_lat0
      assign cmp_vld = s0_vld;
      assign cmp_dat = s0_dat;
    end else begin : g_pipe
      logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
      entry_t             pipe_dat_q [LATENCY];
      entry_t             pipe_dat_d [LATENCY];

      always_comb begin
        pipe_vld_d[0] = s0_vld;
        pipe_dat_d[0] = s0_dat;
        for (int i = 1; i < LATENCY; i++) begin
          pipe_vld_d[i] = pipe_vld_q[i-1];
          pipe_dat_d[i] = pipe_dat_q[i-1];
        end
      end

      // Only the valid bits are reset; stale payload is harmless behind a cleared valid.
      always_ff @(posedge clk_i) begin
        if (rst_i) pipe_vld_q <= '0;
        else       pipe_vld_q <= pipe_vld_d;
      end

      always_ff @(posedge clk_i) begin
        pipe_dat_q <= pipe_dat_d;
      end

      assign cmp_vld = pipe_vld_q[LATENCY-1];
      assign cmp_dat = pipe_dat_q[LATENCY-1];
    end
  endgenerate

  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, skip_q, skip_d;
  logic             err_q, err_d;
  logic [5:0]       ff_op_q, ff_op_d;
  logic [31:0]      ff_exp_q, ff_exp_d, ff_act_q, ff_act_d;

  // Compare stage: clear wins over a same-cycle compare.
  always_comb begin
    pass_d   = pass_q;
    fail_d   = fail_q;
    skip_d   = skip_q;
    err_d    = err_q;
    ff_op_d  = ff_op_q;
    ff_exp_d = ff_exp_q;
    ff_act_d = ff_act_q;
    if (clear_i) begin
      pass_d   = '0;
      fail_d   = '0;
      skip_d   = '0;
      err_d    = 1'b0;
      ff_op_d  = '0;
      ff_exp_d = '0;
      ff_act_d = '0;
    end else if (cmp_vld) begin
      if (cmp_dat.skip) begin
        skip_d = sat_inc(skip_q);
      end else if (cmp_dat.exp == result_i) begin
        pass_d = sat_inc(pass_q);
      end else begin
        fail_d = sat_inc(fail_q);
        err_d  = 1'b1;
        if (!err_q) begin
          ff_op_d  = cmp_dat.op;
          ff_exp_d = cmp_dat.exp;
          ff_act_d = result_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pass_q   <= '0;
      fail_q   <= '0;
      skip_q   <= '0;
      err_q    <= 1'b0;
      ff_op_q  <= '0;
      ff_exp_q <= '0;
      ff_act_q <= '0;
    end else begin
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      skip_q   <= skip_d;
      err_q    <= err_d;
      ff_op_q  <= ff_op_d;
      ff_exp_q <= ff_exp_d;
      ff_act_q <= ff_act_d;
    end
  end

  assign pass_count_o     = pass_q;
  assign fail_count_o     = fail_q;
  assign skip_count_o     = skip_q;
  assign error_o          = err_q;
  assign first_fail_op_o  = ff_op_q;
  assign first_fail_exp_o = ff_exp_q;
  assign first_fail_act_o = ff_act_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: three instances (LATENCY 1, 2 and 0 with 4-bit counters)
// checked against a behavioural model through per-instance expectation queues.
module tb_alu_result_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clr_b;
  logic        v_ac, v_b;
  logic [5:0]  op_ac, op_b;
  logic [31:0] a_ac, b_ac, a_b, b_b, res_a, res_b, res_c;

  logic [15:0] pass_a, fail_a, skip_a, pass_b, fail_b, skip_b;
  logic [3:0]  pass_c, fail_c, skip_c;
  logic        err_a, err_b, err_c;
  logic [5:0]  ffop_a, ffop_b, ffop_c;
  logic [31:0] ffexp_a, ffexp_b, ffexp_c, ffact_a, ffact_b, ffact_c;

  alu_result_checker #(.LATENCY(1), .CNT_W(16)) u_a (
    .clk_i(clk), .rst_i(rst), .clear_i(1'b0), .valid_i(v_ac), .ALUop_i(op_ac),
    .operand_A_i(a_ac), .operand_B_i(b_ac), .result_i(res_a),
    .pass_count_o(pass_a), .fail_count_o(fail_a), .skip_count_o(skip_a), .error_o(err_a),
    .first_fail_op_o(ffop_a), .first_fail_exp_o(ffexp_a), .first_fail_act_o(ffact_a));

  alu_result_checker #(.LATENCY(2), .CNT_W(16)) u_b (
    .clk_i(clk), .rst_i(rst), .clear_i(clr_b), .valid_i(v_b), .ALUop_i(op_b),
    .operand_A_i(a_b), .operand_B_i(b_b), .result_i(res_b),
    .pass_count_o(pass_b), .fail_count_o(fail_b), .skip_count_o(skip_b), .error_o(err_b),
    .first_fail_op_o(ffop_b), .first_fail_exp_o(ffexp_b), .first_fail_act_o(ffact_b));

  alu_result_checker #(.LATENCY(0), .CNT_W(4)) u_c (
    .clk_i(clk), .rst_i(rst), .clear_i(1'b0), .valid_i(v_ac), .ALUop_i(op_ac),
    .operand_A_i(a_ac), .operand_B_i(b_ac), .result_i(res_c),
    .pass_count_o(pass_c), .fail_count_o(fail_c), .skip_count_o(skip_c), .error_o(err_c),
    .first_fail_op_o(ffop_c), .first_fail_exp_o(ffexp_c), .first_fail_act_o(ffact_c));

  typedef struct {
    int          due;
    int          pass;
    int          fail;
    int          skip;
    bit          err;
    logic [5:0]  op;
    logic [31:0] exp;
    logic [31:0] act;
  } snap_t;

  snap_t qa[$], qb[$], qc[$];
  snap_t ma, mc, mon_s;
  int    edge_n = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  logic [31:0] prev_act = 32'd0;
  logic [5:0]  ops [10] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd13};

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic snap_t mk(int due, int p, int f, int s, bit e, logic [5:0] o,
                               logic [31:0] x, logic [31:0] a);
    snap_t r;
    r.due = due; r.pass = p; r.fail = f; r.skip = s;
    r.err = e; r.op = o; r.exp = x; r.act = a;
    return r;
  endfunction

  // Reference ALU written from the opcode table.
  function automatic void ref_alu(input logic [5:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output bit sup, output logic [31:0] r);
    int sh;
    sh  = int'(b % 32);
    sup = 1'b1;
    case (op)
      6'd0:    r = a + b;
      6'd1:    r = a << sh;
      6'd2:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd3:    r = (a < b) ? 32'd1 : 32'd0;
      6'd4:    r = a ^ b;
      6'd5:    r = a >> sh;
      6'd6:    r = a | b;
      6'd7:    r = a & b;
      6'd8:    r = a - b;
      6'd13:   r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      default: begin sup = 1'b0; r = 32'd0; end
    endcase
  endfunction

  function automatic snap_t model_step(snap_t s, bit v, bit sup, logic [5:0] op,
                                       logic [31:0] e, logic [31:0] act, int maxv);
    if (v) begin
      if (!sup) begin
        if (s.skip < maxv) s.skip++;
      end else if (e == act) begin
        if (s.pass < maxv) s.pass++;
      end else begin
        if (s.fail < maxv) s.fail++;
        if (!s.err) begin
          s.err = 1'b1; s.op = op; s.exp = e; s.act = act;
        end
      end
    end
    return s;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void check_snap(string tag, snap_t s, logic [31:0] p, logic [31:0] f,
                                     logic [31:0] k, logic [31:0] e, logic [31:0] o,
                                     logic [31:0] x, logic [31:0] a);
    chk({tag, "_pass_count"}, p, 32'(s.pass));
    chk({tag, "_fail_count"}, f, 32'(s.fail));
    chk({tag, "_skip_count"}, k, 32'(s.skip));
    chk({tag, "_error"}, e, 32'(s.err));
    chk({tag, "_first_fail_op"}, o, 32'(s.op));
    chk({tag, "_first_fail_exp"}, x, s.exp);
    chk({tag, "_first_fail_act"}, a, s.act);
  endfunction

  // Monitor: compares each expectation once its due edge has passed.
  always @(negedge clk) begin
    while (qa.size() > 0 && qa[0].due <= edge_n) begin
      mon_s = qa.pop_front();
      check_snap("A", mon_s, 32'(pass_a), 32'(fail_a), 32'(skip_a), 32'(err_a),
                 32'(ffop_a), ffexp_a, ffact_a);
    end
    while (qb.size() > 0 && qb[0].due <= edge_n) begin
      mon_s = qb.pop_front();
      check_snap("B", mon_s, 32'(pass_b), 32'(fail_b), 32'(skip_b), 32'(err_b),
                 32'(ffop_b), ffexp_b, ffact_b);
    end
    while (qc.size() > 0 && qc[0].due <= edge_n) begin
      mon_s = qc.pop_front();
      check_snap("C", mon_s, 32'(pass_c), 32'(fail_c), 32'(skip_c), 32'(err_c),
                 32'(ffop_c), ffexp_c, ffact_c);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_zero(int due);
    qa.push_back(mk(due, 0, 0, 0, 1'b0, 6'd0, 32'd0, 32'd0));
    qb.push_back(mk(due, 0, 0, 0, 1'b0, 6'd0, 32'd0, 32'd0));
    qc.push_back(mk(due, 0, 0, 0, 1'b0, 6'd0, 32'd0, 32'd0));
  endtask

  // One cycle of shared stimulus for the LATENCY=1 and LATENCY=0 instances;
  // xr flips bits of the driven result to create mismatches.
  task automatic drive_ac(bit v, logic [5:0] op, logic [31:0] a, logic [31:0] b,
                          logic [31:0] xr);
    bit          sup;
    logic [31:0] e, act;
    ref_alu(op, a, b, sup, e);
    act   = e ^ xr;
    v_ac  = v;  op_ac = op;  a_ac = a;  b_ac = b;
    res_c = act;
    res_a = prev_act;
    prev_act = act;
    mc = model_step(mc, v, sup, op, e, act, 15);
    mc.due = edge_n + 1;
    qc.push_back(mc);
    ma = model_step(ma, v, sup, op, e, act, 65535);
    ma.due = edge_n + 2;
    qa.push_back(ma);
    step();
  endtask

  task automatic idle_ac(int n);
    for (int i = 0; i < n; i++) begin
      v_ac  = 1'b0;
      res_a = prev_act;
      step();
    end
  endtask

  bit          r_v;
  logic [5:0]  r_op;
  logic [31:0] r_a, r_b, r_x;
  int          m;

  initial begin
    rst = 1'b1; clr_b = 1'b0;
    v_ac = 1'b0; op_ac = 6'd0; a_ac = 32'd0; b_ac = 32'd0; res_a = 32'd0; res_c = 32'd0;
    v_b = 1'b0; op_b = 6'd0; a_b = 32'd0; b_b = 32'd0; res_b = 32'd0;
    ma = mk(0, 0, 0, 0, 1'b0, 6'd0, 32'd0, 32'd0);
    mc = ma;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    push_zero(edge_n);

    // Directed cases from the operation table.
    drive_ac(1'b1, 6'd0, 32'd200, 32'd14, 32'd0);
    drive_ac(1'b1, 6'd1, 32'd200, 32'd14, 32'd0);
    drive_ac(1'b1, 6'd2, 32'd200, 32'd14, 32'd0);
    drive_ac(1'b1, 6'd3, 32'd200, 32'd14, 32'd0);
    drive_ac(1'b1, 6'd4, 32'd200, 32'd14, 32'd0);
    drive_ac(1'b1, 6'd8, 32'd14, 32'd200, 32'd0);
    drive_ac(1'b1, 6'd13, 32'h8000_0000, 32'd31, 32'd0);
    drive_ac(1'b1, 6'd0, 32'd200, 32'd14, 32'd1);
    drive_ac(1'b1, 6'd7, 32'd200, 32'd14, 32'h10);
    drive_ac(1'b1, 6'b111111, 32'd200, 32'd14, 32'h1234);
    drive_ac(1'b0, 6'd0, 32'd1, 32'd1, 32'h5);

    for (int i = 0; i < 200; i++) begin
      r_v  = ($urandom_range(0, 9) < 8);
      r_op = ($urandom_range(0, 11) < 10) ? ops[$urandom_range(0, 9)] : 6'($urandom);
      r_a  = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      r_b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      r_x  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'd1) : 32'd0;
      drive_ac(r_v, r_op, r_a, r_b, r_x);
    end

    for (int i = 0; i < 20; i++) drive_ac(1'b1, 6'd0, $urandom, $urandom, 32'd0);
    idle_ac(4);

    // LATENCY=2: two mismatches in flight, clear on the first compare.
    m = edge_n;
    v_b = 1'b1; op_b = 6'd0; a_b = 32'd200; b_b = 32'd14; res_b = 32'd0;
    step();
    op_b = 6'd7;
    qb.push_back(mk(m + 2, 0, 0, 0, 1'b0, 6'd0, 32'd0, 32'd0));
    step();
    v_b = 1'b0; res_b = 32'd215; clr_b = 1'b1;
    qb.push_back(mk(m + 3, 0, 0, 0, 1'b0, 6'd0, 32'd0, 32'd0));
    step();
    clr_b = 1'b0; res_b = 32'h108;
    qb.push_back(mk(m + 4, 0, 1, 0, 1'b1, 6'd7, 32'd8, 32'h108));
    step();

    // Reset with transactions in flight: they must never be counted.
    v_b = 1'b1; op_b = 6'd8; a_b = 32'd5; b_b = 32'd3; res_b = 32'd0;
    step();
    rst = 1'b1; op_b = 6'd4; a_b = 32'd1; b_b = 32'd2; res_b = 32'd7;
    step();
    rst = 1'b0; v_b = 1'b0; res_b = 32'd123;
    push_zero(edge_n);
    qb.push_back(mk(edge_n + 1, 0, 0, 0, 1'b0, 6'd0, 32'd0, 32'd0));
    qb.push_back(mk(edge_n + 2, 0, 0, 0, 1'b0, 6'd0, 32'd0, 32'd0));
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
